// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL lock sequencer control/status bundle
// master = sequencer side, slave = PLL / system side.
interface pll_lock_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   locked;
  logic                   restart;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   pll_ok;
  logic                   fault;
  logic                   lock_lost;
  logic [1:0]             retry_cnt;

  modport master (
    input  locked, restart,
    output pll_rst, dom_rst_n, pll_ok, fault, lock_lost, retry_cnt
  );

  modport slave (
    output locked, restart,
    input  pll_rst, dom_rst_n, pll_ok, fault, lock_lost, retry_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock qualification and staged domain reset release
// Runs on refclk; all outputs are registered levels.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP   = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int NUM_DOMAINS   = 3
) (
  input  logic                i_refclk,
  input  logic                i_rst_n,
  pll_lock_sequencer_if.master seq_if
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int REL_END = NUM_DOMAINS * RELEASE_GAP;
  localparam int MAX_B   = (STABLE_CYCLES > REL_END) ? STABLE_CYCLES : REL_END;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(REL_END);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_lock_meta;
  logic                   r_locked_s;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_dom_rst_n;
  logic                   r_pll_ok;
  logic                   r_fault;
  logic                   r_lock_lost;
  logic [1:0]             r_retry_cnt;
  logic [CW-1:0]          w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
    end else begin
      r_lock_meta <= seq_if.locked;
      r_locked_s  <= r_lock_meta;
    end
  end

  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_dom_rst_n <= '0;
      r_pll_ok    <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_lock_lost <= 1'b0;
      r_cnt       <= w_cnt_inc;
      if (seq_if.restart) begin
        r_state     <= S_RESET_PLL;
        r_cnt       <= '0;
        r_retry_cnt <= '0;
        r_pll_rst   <= 1'b1;
        r_dom_rst_n <= '0;
        r_pll_ok    <= 1'b0;
        r_fault     <= 1'b0;
      end else if ((r_state == S_RELEASE || r_state == S_RUN) && !r_locked_s) begin
        r_state     <= S_RESET_PLL;
        r_cnt       <= '0;
        r_retry_cnt <= '0;
        r_lock_lost <= 1'b1;
        r_pll_rst   <= 1'b1;
        r_dom_rst_n <= '0;
        r_pll_ok    <= 1'b0;
      end else begin
        case (r_state)
          S_RESET_PLL: begin
            r_pll_rst   <= 1'b1;
            r_dom_rst_n <= '0;
            if (r_cnt == RST_LAST) begin
              r_state   <= S_WAIT_LOCK;
              r_cnt     <= '0;
              r_pll_rst <= 1'b0;
            end
          end
          S_WAIT_LOCK: begin
            // A lock seen in the timeout cycle itself takes precedence.
            if (r_locked_s) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == TO_LAST) begin
              r_cnt     <= '0;
              r_pll_rst <= 1'b1;
              if (r_retry_cnt < RETRY_MAX) begin
                r_retry_cnt <= r_retry_cnt + 2'd1;
                r_state     <= S_RESET_PLL;
              end else begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end
            end
          end
          S_STABLE: begin
            if (!r_locked_s) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == STB_LAST) begin
              r_state <= S_RELEASE;
              r_cnt   <= '0;
            end
          end
          S_RELEASE: begin
            if (r_cnt == REL_LAST) begin
              r_state     <= S_RUN;
              r_cnt       <= '0;
              r_pll_ok    <= 1'b1;
              r_retry_cnt <= '0;
            end else begin
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (w_cnt_inc == CW'((i + 1) * RELEASE_GAP)) r_dom_rst_n[i] <= 1'b1;
              end
            end
          end
          S_RUN: begin
            r_cnt <= '0;
          end
          S_FAULT: begin
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_dom_rst_n <= '0;
            r_fault     <= 1'b1;
          end
          default: begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign seq_if.pll_rst   = r_pll_rst;
  assign seq_if.dom_rst_n = r_dom_rst_n;
  assign seq_if.pll_ok    = r_pll_ok;
  assign seq_if.fault     = r_fault;
  assign seq_if.lock_lost = r_lock_lost;
  assign seq_if.retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
// Small parameter set so every sequence completes in a few hundred cycles.
module tb_pll_lock_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pll_lock_sequencer_if #(.NUM_DOMAINS(3)) sif ();

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .RELEASE_GAP  (2),
    .MAX_RETRIES  (2),
    .NUM_DOMAINS  (3)
  ) dut (
    .i_refclk(clk),
    .i_rst_n (rst_n),
    .seq_if  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts sampled cycles while pll_rst holds lvl; bounded so a stuck DUT still ends.
  task automatic count_run(input logic lvl, output int n, output int ll);
    n  = 0;
    ll = 0;
    while (sif.pll_rst == lvl && n < 200) begin
      n++;
      if (sif.lock_lost) ll++;
      tick(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, ll, first_k, ll_sum;
    n_tests = 0;
    n_fail  = 0;
    rst_n       = 1'b0;
    sif.locked  = 1'b0;
    sif.restart = 1'b0;
    tick(2);
    check_eq("rst_pll_rst", sif.pll_rst, 1);
    check_eq("rst_dom", sif.dom_rst_n, 0);
    check_eq("rst_pll_ok", sif.pll_ok, 0);
    check_eq("rst_fault", sif.fault, 0);
    check_eq("rst_lock_lost", sif.lock_lost, 0);
    check_eq("rst_retry", sif.retry_cnt, 0);
    rst_n = 1'b1;

    // Clean start
    count_run(1'b1, n, ll);
    check_eq("clean_rst_len", n, 4);
    tick(3);
    sif.locked = 1'b1;
    tick(12);
    check_eq("clean_dom_pre", sif.dom_rst_n, 3'b000);
    tick(1);
    check_eq("clean_dom0", sif.dom_rst_n, 3'b001);
    tick(1);
    check_eq("clean_dom0_hold", sif.dom_rst_n, 3'b001);
    tick(1);
    check_eq("clean_dom1", sif.dom_rst_n, 3'b011);
    tick(2);
    check_eq("clean_dom2", sif.dom_rst_n, 3'b111);
    check_eq("clean_ok_pre", sif.pll_ok, 0);
    tick(1);
    check_eq("clean_ok", sif.pll_ok, 1);
    check_eq("clean_retry", sif.retry_cnt, 0);

    // Loss in RUN
    sif.locked = 1'b0;
    tick(2);
    check_eq("loss_ll_pre", sif.lock_lost, 0);
    check_eq("loss_dom_pre", sif.dom_rst_n, 3'b111);
    tick(1);
    check_eq("loss_dom", sif.dom_rst_n, 3'b000);
    check_eq("loss_ok", sif.pll_ok, 0);
    count_run(1'b1, n, ll);
    check_eq("loss_rst_len", n, 4);
    check_eq("loss_ll_pulses", ll, 1);

    // Never lock: two retries then FAULT
    for (int i = 0; i < 2; i++) begin
      count_run(1'b0, n, ll);
      check_eq("nolock_wait_len", n, 20);
      check_eq("nolock_retry", sif.retry_cnt, i + 1);
      count_run(1'b1, n, ll);
      check_eq("nolock_rst_len", n, 4);
    end
    count_run(1'b0, n, ll);
    check_eq("nolock_last_wait", n, 20);
    check_eq("fault_set", sif.fault, 1);
    check_eq("fault_retry", sif.retry_cnt, 2);
    tick(5);
    check_eq("fault_hold", sif.fault, 1);
    check_eq("fault_pll_rst", sif.pll_rst, 1);
    check_eq("fault_dom", sif.dom_rst_n, 0);
    sif.restart = 1'b1;
    tick(1);
    sif.restart = 1'b0;
    check_eq("restart_fault", sif.fault, 0);
    check_eq("restart_retry", sif.retry_cnt, 0);
    count_run(1'b1, n, ll);
    check_eq("restart_rst_len", n, 4);

    // Glitchy lock: 5 high, 1 low, then steady
    sif.locked = 1'b1;
    tick(5);
    sif.locked = 1'b0;
    tick(1);
    sif.locked = 1'b1;
    first_k = 0;
    ll_sum  = 0;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      if (sif.lock_lost) ll_sum++;
      if (first_k == 0 && sif.dom_rst_n != 3'b000) first_k = k;
    end
    check_eq("glitch_release_delay", first_k, 13);
    check_eq("glitch_no_ll", ll_sum, 0);
    check_eq("glitch_retry", sif.retry_cnt, 0);
    tick(1);
    check_eq("glitch_dom_hold", sif.dom_rst_n, 3'b001);

    // rst_n mid-RELEASE
    rst_n = 1'b0;
    tick(1);
    rst_n      = 1'b1;
    sif.locked = 1'b0;
    check_eq("midrst_pll_rst", sif.pll_rst, 1);
    check_eq("midrst_dom", sif.dom_rst_n, 0);
    check_eq("midrst_ok", sif.pll_ok, 0);
    check_eq("midrst_fault", sif.fault, 0);
    check_eq("midrst_ll", sif.lock_lost, 0);

    // restart coincident with timeout
    count_run(1'b1, n, ll);
    check_eq("coll_rst_len", n, 4);
    count_run(1'b0, n, ll);
    check_eq("coll_wait_len", n, 20);
    check_eq("coll_retry1", sif.retry_cnt, 1);
    count_run(1'b1, n, ll);
    tick(19);
    check_eq("coll_waiting", sif.pll_rst, 0);
    sif.restart = 1'b1;
    tick(1);
    sif.restart = 1'b0;
    check_eq("coll_retry0", sif.retry_cnt, 0);
    check_eq("coll_pll_rst", sif.pll_rst, 1);
    check_eq("coll_no_fault", sif.fault, 0);
    count_run(1'b1, n, ll);
    check_eq("coll_rst_len2", n, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
